notg_pipe: RTL and testbench
============================

Name: notg_pipe

Overview:
- Parametrised, pipelined successor to the single-bit NOT gate: a WIDTH-bit inverter bank with selectable per-beat inversion mode and DEPTH registered stages.
- Uses a valid/ready handshake with full backpressure.
- Sits between a producer and consumer stream as a drop-in registered bit-inversion stage; also counts delivered beats for debug.

Parameters:
- WIDTH, 8, data bits per beat (>=1).
- DEPTH, 2, number of pipeline register stages (>=1); sets latency.
- CNT_W, 16, width of delivered-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  input beat.
- in_mode  in  2  inversion mode for this beat (encoding below).
- in_mask  in  WIDTH  per-bit mask used by masked modes.
- out_valid  out  1  output beat available.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  WIDTH  transformed beat.
- beat_cnt  out  CNT_W  count of beats delivered (out_valid && out_ready).

Behaviour:
- Reset (async assert on rst_n low, sync deassert by the integrator):
  - all stage valid bits = 0, so out_valid = 0;
  - out_data = 0, beat_cnt = 0;
  - in_ready = 1 combinationally after reset.
- Mode encoding, applied to in_data at capture, so mode and mask are sampled per beat:
  - MODE_PASS = 2'b00: out = in_data.
  - MODE_INV = 2'b01: out = ~in_data.
  - MODE_MASK = 2'b10: out = in_data ^ in_mask (invert bits where mask = 1).
  - MODE_NMASK = 2'b11: out = in_data ^ ~in_mask (invert bits where mask = 0).
- Pipeline:
  - Stages s[0..DEPTH-1], each holding a valid bit v[k] and WIDTH data bits.
  - Stage DEPTH-1 drives out_valid and out_data.
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1] for k < DEPTH-1.
  - in_ready = adv[0]. It is combinational from out_ready; there is no skid buffer.
  - On adv[k]:
    - stage 0 loads v = in_valid and the transformed data;
    - stage k>0 loads from stage k-1.
  - On !adv[k], the stage holds.
  - Data registers load only when the incoming valid = 1; the valid bit always updates on adv.
- Latency: a beat accepted in cycle T appears on out_valid in cycle T+DEPTH when not stalled.
- Throughput: 1 beat/cycle with out_ready held high. Bubbles collapse: an empty stage loads even while downstream is stalled.
- Backpressure: with out_ready = 0, out_data and out_valid hold stable until accepted. The pipe fills to DEPTH beats, then in_ready drops to 0.
- Simultaneous accept and deliver when full: allowed in the same cycle; occupancy is unchanged.
- Mode or mask change between beats affects only newly captured beats; in-flight beats are unaffected.
- in_valid while in_ready = 0: the beat is not captured; the producer must hold it (AXI-style rule).
- beat_cnt:
  - +1 per cycle with out_valid && out_ready;
  - wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset mid-operation: all in-flight beats are discarded, and beat_cnt clears immediately (asynchronously).
- Whole block is synchronous to clk except the reset.

Decomposition:
- Shared package notg_pkg:
  - mode localparams MODE_PASS, MODE_INV, MODE_MASK, MODE_NMASK;
  - function notg_xform(data, mode, mask) returning the transformed word.
- Sub-module notg_stage:
  - one valid/data register with load-enable and async reset;
  - instantiated DEPTH times via generate.
- Top-level notg_pipe contains the adv chain, the input transform and beat_cnt.

Test Plan (WIDTH=8, DEPTH=2, CNT_W=4 unless noted):
1. Reset, then single beat data=8'hA5 mode=01 with out_ready=1.
   -> out_valid rises exactly 2 cycles later with out_data=8'h5A; beat_cnt=1.
2. Mode sweep: data=8'h0F, mask=8'h3C with modes 00/01/10/11 back-to-back.
   -> outputs 8'h0F, 8'hF0, 8'h33, 8'hCC in order on consecutive cycles.
3. Backpressure: out_ready=0, stream 3 beats (8'h01, 8'h02, 8'h03, mode=01).
   -> in_ready falls after 2 accepts; out_data holds 8'hFE.
   -> on out_ready=1, the sequence FE, FD, FC delivers with no loss or duplication.
4. Full-rate stream of 20 beats with out_ready=1, plus random out_ready toggling in a second pass.
   -> scoreboard matches every beat in order.
   -> beat_cnt wraps 15->0 and ends at 4 after 20 beats.
5. Reset mid-operation: rst_n low with pipe full.
   -> out_valid=0, out_data=0, beat_cnt=0 immediately, without waiting for clk.
   -> after release, no stale beat appears; a new beat 8'h00 mode=01 yields 8'hFF.
6. Parameter check: WIDTH=1, DEPTH=1.
   -> reproduces the original gate behaviour (a=0 gives out=1, a=1 gives out=0) with 1-cycle latency.

Source files
------------

// File: rtl/notg_pkg.sv
// notg_pkg: mode encodings and the per-bit transform shared by the inverter pipe
package notg_pkg;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_MASK  = 2'b10;
    localparam logic [1:0] MODE_NMASK = 2'b11;

    // Transform of one data bit; every mode is bitwise, so a word is built bit by bit
    function automatic logic notg_xform(input logic data, input logic [1:0] mode, input logic mask);
        return (mode == MODE_PASS) ? data :
               (mode == MODE_INV)  ? ~data :
               (mode == MODE_MASK) ? data ^ mask : data ^ ~mask;
    endfunction

endpackage

// File: rtl/notg_stage.sv
// notg_stage: one valid/data pipeline register with load enable and async clear
module notg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Valid follows its source on every advance; data only latches real beats
    always_comb begin
        valid_d = load ? in_valid : valid_q;
        data_d  = (load && in_valid) ? in_data : data_q;
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/notg_pipe.sv
// notg_pipe: pipelined WIDTH-bit inverter bank with per-beat mode, valid/ready flow and beat counter
module notg_pipe
    import notg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] xform;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             fire;

    // Mode and mask are applied as the beat enters stage 0, so in-flight beats keep their own mode
    always_comb begin
        xform = '0;
        for (int i = 0; i < WIDTH; i++) xform[i] = notg_xform(in_data[i], in_mode, in_mask[i]);
    end

    // A stage advances unless it and every stage after it are full while the sink stalls
    always_comb begin
        logic full;
        full = 1'b1;
        adv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full   = full & v[k];
            adv[k] = out_ready | ~full;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            notg_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (adv[k]),
                .in_valid (in_valid),
                .in_data  (xform),
                .out_valid(v[k]),
                .out_data (d[k])
            );
        end else begin : g_body
            notg_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (adv[k]),
                .in_valid (v[k-1]),
                .in_data  (d[k-1]),
                .out_valid(v[k]),
                .out_data (d[k])
            );
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign fire      = out_valid && out_ready;

    // Delivered-beat count, free-running wrap
    always_comb cnt_d = cnt_q + CNT_W'(fire);

    // Counter register, cleared asynchronously with the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_notg_pipe.sv
// tb_notg_pipe: scoreboard plus table-driven checks of the notg_pipe inverter pipeline
module tb_notg_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, in_mask, out_data;
    logic [1:0] in_mode;
    logic [3:0] beat_cnt;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_in_data, b_in_mask, b_out_data;
    logic [1:0] b_in_mode;
    logic [3:0] b_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    bit         done;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] m;
        logic [7:0] k;
        logic [7:0] e;
    } vec_t;

    typedef struct packed {
        logic a;
        logic e;
    } gate_t;

    vec_t  sweep [4];
    gate_t gate [2];

    notg_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    notg_pipe #(.WIDTH(1), .DEPTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_mask(b_in_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .beat_cnt(b_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
        case (m)
            2'd0:    return d;
            2'd1:    return ~d;
            2'd2:    return d ^ k;
            default: return ~(d ^ k);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: scoreboard push on accept, pop/compare on delivery, beat counter tracking
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 4'd0;
        end else begin
            check("beat_cnt_track", 32'(beat_cnt), 32'(exp_cnt));
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got beat %h expected none", out_data);
                end else begin
                    check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                exp_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode, in_mask));
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
        int n;
        n = 0;
        in_data  = d;
        in_mode  = m;
        in_mask  = k;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sweep[0] = '{d: 8'h0F, m: 2'b00, k: 8'h3C, e: 8'h0F};
        sweep[1] = '{d: 8'h0F, m: 2'b01, k: 8'h3C, e: 8'hF0};
        sweep[2] = '{d: 8'h0F, m: 2'b10, k: 8'h3C, e: 8'h33};
        sweep[3] = '{d: 8'h0F, m: 2'b11, k: 8'h3C, e: 8'hCC};
        gate[0]  = '{a: 1'b0, e: 1'b1};
        gate[1]  = '{a: 1'b1, e: 1'b0};

        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_mask = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 1'b0; b_in_mode = 2'b01; b_in_mask = 1'b0; b_out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_beat_cnt", 32'(beat_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beat latency
        send(8'hA5, 2'b01, 8'h00);
        check("t1_not_yet", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_data", 32'(out_data), 32'h5A);
        @(posedge clk); #1;
        check("t1_beat_cnt", 32'(beat_cnt), 1);
        check("t1_drained", 32'(out_valid), 0);

        // Mode sweep from the vector table
        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) send(sweep[i].d, sweep[i].m, sweep[i].k);
        repeat (4) @(posedge clk);
        #1;
        check("t2_count", 32'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check("t2_data", 32'(got_q[i]), 32'(sweep[i].e));
            check("t2_back_to_back", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
        end

        // Backpressure fill, hold and drain
        got_q.delete();
        out_ready = 1'b0;
        send(8'h01, 2'b01, 8'h00);
        send(8'h02, 2'b01, 8'h00);
        in_data = 8'h03; in_mode = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        check("t3_full_ready", 32'(in_ready), 0);
        check("t3_out_valid", 32'(out_valid), 1);
        check("t3_hold", 32'(out_data), 32'hFE);
        repeat (3) @(negedge clk);
        check("t3_hold_later", 32'(out_data), 32'hFE);
        check("t3_still_full", 32'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_comb", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t3_count", 32'(got_q.size()), 3);
        if (got_q.size() == 3) begin
            check("t3_b0", 32'(got_q[0]), 32'hFE);
            check("t3_b1", 32'(got_q[1]), 32'hFD);
            check("t3_b2", 32'(got_q[2]), 32'hFC);
        end

        // Full-rate random stream, counter wrap
        do_reset();
        for (int i = 0; i < 20; i++) send(8'($urandom), 2'($urandom), 8'($urandom));
        repeat (4) @(posedge clk);
        #1;
        check("t4_cnt_wrap", 32'(beat_cnt), 4);
        check("t4_sb_empty", 32'(exp_q.size()), 0);

        // Random backpressure pass
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(8'($urandom), 2'($urandom), 8'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_cnt_pass2", 32'(beat_cnt), 8);
        check("t4_sb_empty2", 32'(exp_q.size()), 0);

        // Asynchronous reset with the pipe full
        out_ready = 1'b0;
        send(8'h11, 2'b00, 8'h00);
        send(8'h22, 2'b00, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_out_data", 32'(out_data), 0);
        check("t5_beat_cnt", 32'(beat_cnt), 0);
        check("t5_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_stale", 32'(got_q.size()), 0);
        check("t5_idle", 32'(out_valid), 0);
        send(8'h00, 2'b01, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("t5_new_count", 32'(got_q.size()), 1);
        if (got_q.size() == 1) check("t5_new_data", 32'(got_q[0]), 32'hFF);

        // Single-bit, single-stage gate from the table
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1;
            b_in_data  = gate[i].a;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            check("t6_valid", 32'(b_out_valid), 1);
            check("t6_data", 32'(b_out_data), 32'(gate[i].e));
        end
        @(posedge clk); #1;
        check("t6_drained", 32'(b_out_valid), 0);
        check("t6_cnt", 32'(b_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
